// File: rtl/tile_coordinator.sv
// -----------------------------------------------------------------------------
// tile_coordinator
//   Sends candidate messages from the generator to an array of SHA-1 tiles.
//   Collects the digest-match flag that each tile returns.
//   Keeps a copy of each tile's in-flight message, so a match is reported as
//   the original message. Each tile has its own valid/ready pair, so the
//   solver no longer needs a shared tile_id select.
//
//   Ports
//     clk_i, rst_i          clock; asynchronous active-high reset
//     enable_i              level: 0 stops new dispatches, in-flight work drains
//     msg_val_i/msg_i       generator message and its valid
//     msg_rdy_o             coordinator accepts msg_i this cycle
//     tile_val_o            one-hot message valid to the tiles
//     tile_msg_o            message to the tiles (msg_i passed through)
//     tile_rdy_i            per-tile message ready
//     dgst_val_i/dgst_i     per-tile result valid and match flag
//     dgst_rdy_o            one-hot result acknowledge
//     result_o              message whose digest matched
//     result_val_o          sticky: result_o holds a match
//     tries_o               number of digest results consumed (wraps)
//     busy_o                per-tile in-flight flags
// -----------------------------------------------------------------------------
module tile_coordinator #(
   parameter int MSG_LEN = 1234,
   parameter int TILES   = 2,
   parameter int CNT_W   = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic               msg_val_i,
   input  logic [MSG_LEN-1:0] msg_i,
   output logic               msg_rdy_o,
   output logic [TILES-1:0]   tile_val_o,
   output logic [MSG_LEN-1:0] tile_msg_o,
   input  logic [TILES-1:0]   tile_rdy_i,
   input  logic [TILES-1:0]   dgst_val_i,
   input  logic [TILES-1:0]   dgst_i,
   output logic [TILES-1:0]   dgst_rdy_o,
   output logic [MSG_LEN-1:0] result_o,
   output logic               result_val_o,
   output logic [CNT_W-1:0]   tries_o,
   output logic [TILES-1:0]   busy_o
);

   localparam int PTR_W = $clog2(TILES);

   typedef enum logic {
      ST_RUN,
      ST_FOUND
   } state_t;

   state_t             state_q, state_d;
   logic [TILES-1:0]   busy_q;
   logic [MSG_LEN-1:0] msg_buf_q [TILES];
   logic [PTR_W-1:0]   disp_ptr_q, coll_ptr_q;

   logic [TILES-1:0]   eligible, cand;
   logic               disp_hit, coll_hit;
   logic [PTR_W-1:0]   disp_sel, coll_sel;
   logic               msg_fire, coll_fire, match_fire;

   // (base + off) mod TILES. Both operands are below TILES, so one
   // conditional subtract is enough, even when TILES is not a power of two.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
      int unsigned sum;
      sum = int'(base) + off;
      if (sum >= TILES) sum = sum - TILES;
      return PTR_W'(sum);
   endfunction

   // -------------------------------------------------------------------------
   // Next-state, round-robin picks and handshake outputs
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first. A path that
      // leaves a signal unassigned would infer a latch.
      state_d    = state_q;
      disp_hit   = 1'b0;
      disp_sel   = '0;
      coll_hit   = 1'b0;
      coll_sel   = '0;
      msg_rdy_o  = 1'b0;
      tile_val_o = '0;
      dgst_rdy_o = '0;
      msg_fire   = 1'b0;
      coll_fire  = 1'b0;
      match_fire = 1'b0;

      eligible = ~busy_q & tile_rdy_i;
      cand     = busy_q & dgst_val_i;

      // The first hit, scanning from each pointer, wins.
      for (int i = 0; i < TILES; i++) begin
         if (!disp_hit && eligible[wrap_add(disp_ptr_q, i)]) begin
            disp_hit = 1'b1;
            disp_sel = wrap_add(disp_ptr_q, i);
         end
         if (!coll_hit && cand[wrap_add(coll_ptr_q, i)]) begin
            coll_hit = 1'b1;
            coll_sel = wrap_add(coll_ptr_q, i);
         end
      end

      // Handshakes are gated with rst_i. This keeps every output at zero for
      // as long as reset is asserted, not only after the first edge.
      msg_rdy_o = !rst_i && (state_q == ST_RUN) && enable_i && disp_hit;
      msg_fire  = msg_rdy_o && msg_val_i;
      if (msg_fire) tile_val_o[disp_sel] = 1'b1;

      // Collection continues in FOUND, so tiles still in flight drain.
      coll_fire = !rst_i && coll_hit;
      if (coll_fire) dgst_rdy_o[coll_sel] = 1'b1;

      match_fire = coll_fire && dgst_i[coll_sel] && (state_q == ST_RUN);
      if (match_fire) state_d = ST_FOUND;
   end

   assign tile_msg_o = msg_i;
   assign busy_o     = busy_q;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples pre-edge values, whatever the process order.
      if (rst_i) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   // -------------------------------------------------------------------------
   // Tile bookkeeping, counter and result capture
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q       <= '0;
         disp_ptr_q   <= '0;
         coll_ptr_q   <= '0;
         tries_o      <= '0;
         result_o     <= '0;
         result_val_o <= 1'b0;
         // NOTE: the message buffers are reset on purpose, so no stale
         // message survives a reset. Storage that is only read after a write
         // would normally be left without reset.
         for (int t = 0; t < TILES; t++) msg_buf_q[t] <= '0;
      end else begin
         // Collect and dispatch never select the same tile in one cycle:
         // collect needs busy, dispatch needs idle. The two busy updates
         // below therefore touch different bits.
         if (coll_fire) begin
            busy_q[coll_sel] <= 1'b0;
            tries_o          <= tries_o + CNT_W'(1);
            coll_ptr_q       <= wrap_add(coll_sel, 1);
         end
         if (match_fire) begin
            result_o     <= msg_buf_q[coll_sel];
            result_val_o <= 1'b1;
         end
         if (msg_fire) begin
            busy_q[disp_sel]    <= 1'b1;
            msg_buf_q[disp_sel] <= msg_i;
            disp_ptr_q          <= wrap_add(disp_sel, 1);
         end
      end
   end

endmodule

// File: tb/tb_tile_coordinator.sv
// -----------------------------------------------------------------------------
// tb_tile_coordinator
//   Self-checking bench for tile_coordinator.
//   The bench plays both the generator and the tiles.
//   A reference model tracks, per tile, whether it is idle or holding a
//   message. It also tracks the round-robin start points, the FOUND flag and
//   the attempt count, and it predicts every handshake output each cycle.
//   A match that is accepted before FOUND pushes the held message onto a
//   scoreboard queue. A separate monitor pops that queue whenever
//   result_val_o rises.
// -----------------------------------------------------------------------------
module tb_tile_coordinator;

   localparam int MSG_LEN = 1234;
   localparam int TILES   = 2;
   localparam int CNT_W   = 64;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               enable_i;
   logic               msg_val_i;
   logic [MSG_LEN-1:0] msg_i;
   logic               msg_rdy_o;
   logic [TILES-1:0]   tile_val_o;
   logic [MSG_LEN-1:0] tile_msg_o;
   logic [TILES-1:0]   tile_rdy_i;
   logic [TILES-1:0]   dgst_val_i;
   logic [TILES-1:0]   dgst_i;
   logic [TILES-1:0]   dgst_rdy_o;
   logic [MSG_LEN-1:0] result_o;
   logic               result_val_o;
   logic [CNT_W-1:0]   tries_o;
   logic [TILES-1:0]   busy_o;

   always #5 clk_i = ~clk_i;

   tile_coordinator #(.MSG_LEN(MSG_LEN), .TILES(TILES), .CNT_W(CNT_W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .msg_val_i   (msg_val_i),
      .msg_i       (msg_i),
      .msg_rdy_o   (msg_rdy_o),
      .tile_val_o  (tile_val_o),
      .tile_msg_o  (tile_msg_o),
      .tile_rdy_i  (tile_rdy_i),
      .dgst_val_i  (dgst_val_i),
      .dgst_i      (dgst_i),
      .dgst_rdy_o  (dgst_rdy_o),
      .result_o    (result_o),
      .result_val_o(result_val_o),
      .tries_o     (tries_o),
      .busy_o      (busy_o)
   );

   int tests  = 0;
   int failed = 0;

   // Reference model
   bit                 m_busy [TILES];
   logic [MSG_LEN-1:0] m_held [TILES];
   int                 m_disp;
   int                 m_coll;
   bit                 m_found;
   logic [CNT_W-1:0]   m_tries;
   logic [MSG_LEN-1:0] m_result;
   logic [MSG_LEN-1:0] exp_q [$];

   // Outputs sampled by the last step (used by directed checks)
   logic               s_msg_rdy;
   logic [TILES-1:0]   s_tile_val, s_dgst_rdy, s_busy;
   logic [CNT_W-1:0]   s_tries;
   logic               mon_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_msg(input string name, input logic [MSG_LEN-1:0] act,
                            input logic [MSG_LEN-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got ..%016h expected ..%016h (low 64 bits)",
                  name, act[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [MSG_LEN-1:0] rand_msg();
      logic [MSG_LEN-1:0] m = '0;
      for (int i = 0; i < (MSG_LEN + 31) / 32; i++) m = (m << 32) | MSG_LEN'($urandom);
      return m;
   endfunction

   function automatic logic [MSG_LEN-1:0] fill_5a();
      logic [MSG_LEN-1:0] m = '0;
      for (int i = 0; i < (MSG_LEN + 7) / 8; i++) m = (m << 8) | MSG_LEN'(8'h5A);
      return m;
   endfunction

   task automatic model_clear();
      for (int t = 0; t < TILES; t++) begin
         m_busy[t] = 1'b0;
         m_held[t] = '0;
      end
      m_disp   = 0;
      m_coll   = 0;
      m_found  = 1'b0;
      m_tries  = '0;
      m_result = '0;
      exp_q.delete();
   endtask

   // Assert reset between edges and check that the outputs clear at once.
   // The inputs are driven so that ungated outputs would show up.
   task automatic do_reset();
      rst_i      = 1'b1;
      enable_i   = 1'b1;
      msg_val_i  = 1'b1;
      tile_rdy_i = '1;
      dgst_val_i = '1;
      dgst_i     = '1;
      #1;
      check("rst_msg_rdy",  msg_rdy_o, 0);
      check("rst_tile_val", tile_val_o, 0);
      check("rst_dgst_rdy", dgst_rdy_o, 0);
      check("rst_busy",     busy_o, 0);
      check("rst_tries",    tries_o, 0);
      check("rst_res_val",  result_val_o, 0);
      check_msg("rst_result", result_o, '0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      model_clear();
   endtask

   // Run one clock cycle. Entered and left at posedge + 1.
   task automatic step(input logic en, input logic mv, input logic [MSG_LEN-1:0] m,
                       input logic [TILES-1:0] trdy, input logic [TILES-1:0] dv,
                       input logic [TILES-1:0] dg);
      int d_pick, c_pick;
      logic [TILES-1:0] e_tv, e_dr, e_busy;
      enable_i   = en;
      msg_val_i  = mv;
      msg_i      = m;
      tile_rdy_i = trdy;
      dgst_val_i = dv;
      dgst_i     = dg;
      @(negedge clk_i);
      d_pick = -1;
      c_pick = -1;
      for (int k = 0; k < TILES; k++) begin
         int td = (m_disp + k) % TILES;
         int tc = (m_coll + k) % TILES;
         if (d_pick < 0 && !m_found && en && !m_busy[td] && trdy[td]) d_pick = td;
         if (c_pick < 0 && m_busy[tc] && dv[tc]) c_pick = tc;
      end
      e_tv = '0;
      e_dr = '0;
      if (d_pick >= 0 && mv) e_tv[d_pick] = 1'b1;
      if (c_pick >= 0) e_dr[c_pick] = 1'b1;
      for (int t = 0; t < TILES; t++) e_busy[t] = m_busy[t];

      s_msg_rdy  = msg_rdy_o;
      s_tile_val = tile_val_o;
      s_dgst_rdy = dgst_rdy_o;
      s_busy     = busy_o;
      s_tries    = tries_o;
      check("msg_rdy",    msg_rdy_o, (d_pick >= 0) ? 64'd1 : 64'd0);
      check("tile_val",   tile_val_o, e_tv);
      check("dgst_rdy",   dgst_rdy_o, e_dr);
      check("busy",       busy_o, e_busy);
      check("tries",      tries_o, m_tries);
      check("result_val", result_val_o, m_found);
      check_msg("tile_msg", tile_msg_o, m);
      if (m_found) check_msg("result_hold", result_o, m_result);

      @(posedge clk_i);
      #1;
      if (c_pick >= 0) begin
         m_busy[c_pick] = 1'b0;
         m_tries        = m_tries + 1;
         m_coll         = (c_pick + 1) % TILES;
         if (dg[c_pick] && !m_found) begin
            m_found  = 1'b1;
            m_result = m_held[c_pick];
            exp_q.push_back(m_held[c_pick]);
         end
      end
      if (d_pick >= 0 && mv) begin
         m_busy[d_pick] = 1'b1;
         m_held[d_pick] = m;
         m_disp         = (d_pick + 1) % TILES;
      end
   endtask

   task automatic random_run(input int cycles, input int reset_at);
      logic [TILES-1:0] trdy, dv, dg;
      for (int c = 0; c < cycles; c++) begin
         if (c == reset_at) do_reset();
         for (int t = 0; t < TILES; t++) begin
            trdy[t] = ($urandom_range(3) != 0);
            dv[t]   = m_busy[t] ? ($urandom_range(1) != 0) : ($urandom_range(7) == 0);
            dg[t]   = ($urandom_range(15) == 0);
         end
         step(($urandom_range(9) != 0), ($urandom_range(4) != 0), rand_msg(), trdy, dv, dg);
      end
   endtask

   // Result monitor: each rising result_val_o must match the next expected
   // message on the scoreboard queue.
   initial begin
      forever begin
         @(negedge clk_i);
         if (result_val_o === 1'b1 && !mon_prev) begin
            if (exp_q.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL result_unexpected: result_val_o rose with nothing expected");
            end else begin
               check_msg("result_msg", result_o, exp_q.pop_front());
            end
         end
         mon_prev = (result_val_o === 1'b1);
      end
   end

   initial begin
      logic [MSG_LEN-1:0] ma, mb, mc, md, p5a;
      rst_i      = 1'b1;
      enable_i   = 1'b0;
      msg_val_i  = 1'b0;
      msg_i      = '0;
      tile_rdy_i = '0;
      dgst_val_i = '0;
      dgst_i     = '0;
      model_clear();
      @(posedge clk_i);
      #1;
      do_reset();

      ma  = rand_msg();
      mb  = rand_msg();
      mc  = rand_msg();
      md  = rand_msg();
      p5a = fill_5a();

      // Round robin, stall while both tiles are busy, simultaneous digests,
      // match on tile1, then a post-FOUND drain.
      step(1, 1, ma, 2'b11, 2'b00, 2'b00);
      check("rr_first",  s_tile_val, 2'b01);
      step(1, 1, mb, 2'b11, 2'b00, 2'b00);
      check("rr_second", s_tile_val, 2'b10);
      step(1, 1, mc, 2'b11, 2'b11, 2'b00);
      check("stall_rdy", s_msg_rdy, 0);
      check("simul_t0",  s_dgst_rdy, 2'b01);
      step(1, 1, mc, 2'b11, 2'b10, 2'b00);
      check("simul_t1",  s_dgst_rdy, 2'b10);
      check("c_to_t0",   s_tile_val, 2'b01);
      check("tries_one", s_tries, 1);
      step(1, 1, p5a, 2'b11, 2'b00, 2'b00);
      check("p5a_to_t1", s_tile_val, 2'b10);
      step(1, 1, md, 2'b00, 2'b10, 2'b10);
      check("match_ack", s_dgst_rdy, 2'b10);
      step(1, 1, md, 2'b11, 2'b00, 2'b00);
      check("found_rdy", s_msg_rdy, 0);
      check_msg("found_result", result_o, p5a);
      step(1, 0, md, 2'b11, 2'b01, 2'b01);
      check("drain_ack", s_dgst_rdy, 2'b01);
      step(1, 0, md, 2'b11, 2'b00, 2'b00);
      check("drain_busy",  s_busy, 0);
      check("drain_tries", s_tries, 4);
      check_msg("drain_result", result_o, p5a);

      // enable_i low with one tile busy: no dispatch, but the tile drains.
      do_reset();
      step(1, 1, ma, 2'b01, 2'b00, 2'b00);
      check("en_dispatch", s_tile_val, 2'b01);
      step(0, 1, mb, 2'b11, 2'b00, 2'b00);
      check("en_off_rdy",  s_msg_rdy, 0);
      step(0, 1, mb, 2'b11, 2'b01, 2'b00);
      check("en_off_drain", s_dgst_rdy, 2'b01);
      step(0, 0, mb, 2'b11, 2'b10, 2'b10);
      check("spurious_dgst", s_dgst_rdy, 2'b00);
      check("en_off_busy",   s_busy, 0);

      // Randomized episodes, some with a reset part-way through.
      for (int e = 0; e < 8; e++) begin
         do_reset();
         random_run(300, (e % 2 == 1) ? int'($urandom_range(40, 250)) : -1);
      end

      @(negedge clk_i);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
